mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one 8-bit multiplier.
REQ-002 Parameter TIMEOUT, default 15, maximum WAIT cycles before abort.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 req  input  NREQ  per-requester request, level; held high until that requester's rsp_valid bit pulses.
REQ-006 op_a  input  8*NREQ  multiplicand of requester i in bits [8i+7:8i]; stable while req[i] is high.
REQ-007 op_b  input  8*NREQ  multiplier of requester i in bits [8i+7:8i]; same stability rule as op_a.
REQ-008 gnt  output  NREQ  one-hot grant, high from ISSUE through RESP for the selected requester.
REQ-009 rsp_valid  output  NREQ  one-hot, one-cycle pulse in RESP to the granted requester.
REQ-010 rsp_result  output  16  product, valid while any rsp_valid bit is high.
REQ-011 rsp_err  output  1  high with rsp_valid when the operation timed out.
REQ-012 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-013 mul_a, mul_b  output  8 each  registered operands presented to the multiplier.
REQ-014 mul_done  input  1  multiplier completion flag.
REQ-015 mul_result  input  16  multiplier product, sampled when mul_done is high.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE SHALL go to ISSUE when |req is high, otherwise stay in IDLE.
REQ-018 On the IDLE->ISSUE edge, the block SHALL pick the winner by round-robin from the priority pointer, and SHALL latch the winner's op_a/op_b into mul_a/mul_b and its index into a grant register.
REQ-019 ISSUE SHALL last exactly one cycle with mul_start=1, then go to WAIT.
REQ-020 WAIT SHALL go to RESP on the first cycle that mul_done=1, capturing mul_result and setting rsp_err=0.
REQ-021 WAIT SHALL count cycles; when the count reaches TIMEOUT without mul_done, it SHALL go to RESP with rsp_result=0 and rsp_err=1.
REQ-022 RESP SHALL last exactly one cycle, pulse rsp_valid[grant] and return to IDLE.
REQ-023 On leaving RESP, the pointer SHALL be set to (grant+1) mod NREQ.
REQ-024 Round-robin SHALL scan from the pointer upward with wrap-around; the first set req bit wins.
REQ-025 No requester SHALL wait more than NREQ-1 other grants.
REQ-026 Best-case latency from req rising in IDLE to rsp_valid SHALL be 3 cycles plus the multiplier latency (IDLE, ISSUE, WAIT until done, then RESP).
REQ-027 req inputs SHALL be ignored outside IDLE.
REQ-028 If req[grant] drops mid-operation, the operation SHALL still complete and rsp_valid SHALL still pulse.
REQ-029 mul_done while not in WAIT SHALL be ignored.
REQ-030 mul_done and a timeout in the same cycle SHALL resolve as done: the product is delivered and rsp_err=0.
REQ-031 A request arriving in the RESP cycle SHALL be arbitrated on the next IDLE cycle; there is no back-to-back bypass.
REQ-032 mul_a, mul_b and rsp_result SHALL hold their values until next overwritten.

Reset
REQ-033 While rst=0, the block SHALL force: state=IDLE, pointer=0, wait counter=0, gnt=0, rsp_valid=0, rsp_result=0, rsp_err=0, mul_start=0, mul_a=0, mul_b=0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no rsp_valid pulse; the first grant after reset goes to the lowest-index active requester.

Structure
REQ-035 Shared package mult_arb_pkg SHALL hold the state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11) and the NREQ/TIMEOUT defaults.
REQ-036 The round-robin selection SHALL be a combinational sub-module rr_picker (inputs req and pointer; outputs one-hot winner, winner index and any-valid).
REQ-037 The wait counter SHALL be wide enough for TIMEOUT (4 bits for the default).

Verification
REQ-038 Single request: req=4'b0001, a=8'd13, b=8'd11, multiplier done 4 cycles after start -> gnt[0] high, mul_start pulses once, rsp_valid=4'b0001 with rsp_result=16'd143 and rsp_err=0.
REQ-039 Full contention: req=4'b1111 held -> grants in order 0,1,2,3,0, each followed by exactly one rsp_valid pulse.
REQ-040 Pointer wrap: pointer=3, req=4'b1001 -> requester 3 granted first, then 0.
REQ-041 Timeout: mul_done held low -> rsp_err=1 and rsp_result=0 exactly TIMEOUT cycles after entering WAIT, then back to IDLE.
REQ-042 Boundary cases: operands 8'hFF x 8'hFF -> 16'hFE01; mul_done coincident with the timeout cycle -> product delivered with rsp_err=0.
REQ-043 Reset in WAIT: rst pulsed low -> all outputs zero immediately with no rsp_valid pulse; next req=4'b0110 -> gnt=4'b0010.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding, default
// sizing and width helpers used by the top and the round-robin picker.
package mult_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_RESP  = 2'b11
   } state_t;

   localparam int NREQ_DEF    = 4;
   localparam int TIMEOUT_DEF = 15;
   localparam int OPND_W      = 8;
   localparam int PROD_W      = 16;

   // Index width for a requester count; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // The wait counter must be able to represent the timeout value itself.
   function automatic int cnt_width(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: scans req upward from the pointer with
// wrap-around and reports the first set bit as one-hot and as an index.
module rr_picker
   import mult_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = idx_width(NREQ_DEF)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_win_onehot,
   output logic [IW-1:0]   o_win_idx,
   output logic            o_any
);

   logic w_found;
   int   w_pos;

   always_comb begin
      o_win_onehot = '0;
      o_win_idx    = '0;
      w_found      = 1'b0;
      w_pos        = 0;
      for (int i = 0; i < NREQ; i++) begin
         w_pos = int'(i_ptr) + i;
         if (w_pos >= NREQ) begin
            w_pos = w_pos - NREQ;
         end
         if (!w_found && i_req[IW'(w_pos)]) begin
            w_found                     = 1'b1;
            o_win_onehot[IW'(w_pos)]    = 1'b1;
            o_win_idx                   = IW'(w_pos);
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 8x8 multiplier between NREQ requesters,
// with a bounded wait for completion and an error response on timeout.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [OPND_W*NREQ-1:0] op_a,
   input  logic [OPND_W*NREQ-1:0] op_b,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [PROD_W-1:0]      rsp_result,
   output logic                   rsp_err,
   output logic                   mul_start,
   output logic [OPND_W-1:0]      mul_a,
   output logic [OPND_W-1:0]      mul_b,
   input  logic                   mul_done,
   input  logic [PROD_W-1:0]      mul_result
);

   localparam int IW = idx_width(NREQ);
   localparam int CW = cnt_width(TIMEOUT);

   state_t              r_state;
   logic [IW-1:0]       r_ptr;
   logic [IW-1:0]       r_idx;
   logic [NREQ-1:0]     r_gnt;
   logic [NREQ-1:0]     r_rsp_valid;
   logic [PROD_W-1:0]   r_rsp_result;
   logic                r_rsp_err;
   logic                r_mul_start;
   logic [OPND_W-1:0]   r_mul_a;
   logic [OPND_W-1:0]   r_mul_b;
   logic [CW-1:0]       r_wait_cnt;

   logic [NREQ-1:0]     w_win_onehot;
   logic [IW-1:0]       w_win_idx;
   logic                w_any;
   logic [OPND_W-1:0]   w_op_a;
   logic [OPND_W-1:0]   w_op_b;
   logic                w_timeout;
   logic [IW-1:0]       w_ptr_next;

   rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .i_req        (req),
      .i_ptr        (r_ptr),
      .o_win_onehot (w_win_onehot),
      .o_win_idx    (w_win_idx),
      .o_any        (w_any)
   );

   assign w_op_a     = op_a[{w_win_idx, 3'b000} +: OPND_W];
   assign w_op_b     = op_b[{w_win_idx, 3'b000} +: OPND_W];
   // Last WAIT cycle: the counter starts at zero on entry, so TIMEOUT cycles end at TIMEOUT-1.
   assign w_timeout  = (r_wait_cnt == CW'(TIMEOUT - 1));
   assign w_ptr_next = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_idx        <= '0;
         r_gnt        <= '0;
         r_rsp_valid  <= '0;
         r_rsp_result <= '0;
         r_rsp_err    <= 1'b0;
         r_mul_start  <= 1'b0;
         r_mul_a      <= '0;
         r_mul_b      <= '0;
         r_wait_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state     <= ST_ISSUE;
                  r_idx       <= w_win_idx;
                  r_gnt       <= w_win_onehot;
                  r_mul_a     <= w_op_a;
                  r_mul_b     <= w_op_b;
                  r_mul_start <= 1'b1;
               end
            end
            ST_ISSUE: begin
               r_mul_start <= 1'b0;
               r_wait_cnt  <= '0;
               r_state     <= ST_WAIT;
            end
            ST_WAIT: begin
               // Completion takes priority over a timeout landing in the same cycle.
               if (mul_done) begin
                  r_rsp_result <= mul_result;
                  r_rsp_err    <= 1'b0;
                  r_rsp_valid  <= r_gnt;
                  r_wait_cnt   <= '0;
                  r_state      <= ST_RESP;
               end else if (w_timeout) begin
                  r_rsp_result <= '0;
                  r_rsp_err    <= 1'b1;
                  r_rsp_valid  <= r_gnt;
                  r_wait_cnt   <= '0;
                  r_state      <= ST_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_rsp_valid <= '0;
               r_rsp_err   <= 1'b0;
               r_gnt       <= '0;
               r_ptr       <= w_ptr_next;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign rsp_err    = r_rsp_err;
   assign mul_start  = r_mul_start;
   assign mul_a      = r_mul_a;
   assign mul_b      = r_mul_b;

endmodule
